tap_timer: RTL
==============

# tap_timer

Bank of programmable software-visible timers driven by the `taps` edge strobes of the free-running timebase. Each channel selects one tap, counts its strobes down from a programmed period and emits a one-cycle `fire` pulse on expiry, in one-shot or periodic mode. It sits directly downstream of the timebase. It converts the coarse power-of-two tap strobes into arbitrary-interval events for the rest of the sandbox.

## Interface

Parameters:
- `NTAPS`, 6: number of tap strobe inputs; must match the timebase.
- `NCH`, 4: number of timer channels.
- `CHW`, 2: channel index width; NCH ≤ 2^CHW.
- `TSW`, 3: tap-select width; NTAPS ≤ 2^TSW.
- `CW`, 16: period/counter width.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `taps`  in  NTAPS  one-cycle edge strobes from the timebase; any bit pattern is legal, including several bits high at once.
- `cfg_valid`  in  1  command strobe, sampled every cycle; no backpressure.
- `cfg_ch`  in  CHW  target channel.
- `cfg_start`  in  1  1 = start/restart the channel; 0 = stop it.
- `cfg_mode`  in  1  0 = one-shot, 1 = periodic (used only when `cfg_start`=1).
- `cfg_tap`  in  TSW  tap index counted by the channel.
- `cfg_period`  in  CW  number of strobes per expiry.
- `cfg_err`  out  1  one-cycle pulse: previous-cycle command rejected.
- `fire`  out  NCH  one-cycle expiry pulse per channel.
- `active`  out  NCH  channel running.
- `rd_ch`  in  CHW  readback channel select.
- `rd_count`  out  CW  remaining count of `rd_ch`, registered.

## Operation

- Per-channel state: `tap_sel`, `period`, `mode`, `count`, `active`. Each channel has two states, IDLE (`active`=0) and RUN (`active`=1).
- Start command (`cfg_valid`=1, `cfg_start`=1) with a valid channel, `cfg_tap` < NTAPS and `cfg_period` ≠ 0:
  - latch `tap_sel`, `period` and `mode`;
  - set `count` = `cfg_period`;
  - set `active`=1.
  - This applies in either state; a restart discards the old count.
- Stop command (`cfg_valid`=1, `cfg_start`=0) with a valid channel:
  - `active`=0 and `count`=0.
  - Stopping an idle channel is a legal no-op with no error.
- Rejections: `cfg_ch` ≥ NCH, `cfg_tap` ≥ NTAPS (start only), or `cfg_period`=0 (start only).
  - Channel state is unchanged.
  - `cfg_err` pulses.
- Counting: in RUN, each cycle where `taps[tap_sel]`=1 decrements `count`.
- Expiry: a strobe while `count`=1.
  - `fire[ch]` pulses.
  - Periodic mode: `count` reloads to `period` and the channel stays in RUN.
  - One-shot mode: `count`=0 and the channel goes to IDLE.
- Collision: a command to channel ch in the same cycle as a strobe on ch's selected tap.
  - The command wins; the strobe is not counted and no fire occurs.
  - Strobes on other channels are unaffected.
- Channels are fully independent. Any number of `fire` bits may assert in the same cycle.
- Readback: `rd_count` = `count[rd_ch]` as of the previous cycle's state. If `rd_ch` ≥ NCH, `rd_count` reads 0.

## Timing

- Reset (`rst`=1 at a posedge) clears all state next cycle:
  - `fire`=0, `active`=0, `cfg_err`=0, `rd_count`=0;
  - all `count`, `period`, `tap_sel` and `mode` = 0.
  - Reset overrides any command or strobe in the same cycle. Reset mid-count silently abandons the timers with no fire.
- Command at edge t: `active`, `count` and `cfg_err` are visible after edge t+1. The first countable strobe is the one sampled at edge t+1.
- Strobe at edge t causing expiry: `fire` is high for exactly the cycle after edge t+1. In periodic mode the reloaded `count` is visible at the same time.
- Period P, periodic mode: fire follows every Pth selected strobe, with no drift or lost strobe across reload.
- P=1 periodic: fire follows every selected strobe.
- `count` never wraps; 0 in RUN is unreachable.
- Readback latency: 1 cycle from `rd_ch` to `rd_count`.

## Test plan

- Reset, then start ch0, tap 2, P=3, periodic. Drive strobes on tap 2 at cycles 10, 20, 30, 40, 50, 60. Required: `fire[0]` at 31 and 61 only; `active[0]` stays 1.
- Start ch1, tap 0, P=2, one-shot. Drive strobes at 5, 6, 7. Required: `fire[1]` at 7; `active[1]`=0 from 7; the strobe at 7 is not counted.
- Issue a start for ch2 in the same cycle as a tap strobe for that channel. Required: that strobe is not counted, `rd_count` shows P, and no `cfg_err`.
- Issue starts with `cfg_period`=0, with `cfg_tap`=NTAPS, and with `cfg_ch`=NCH (when NCH < 2^CHW). Required: `cfg_err` pulses one cycle later for each, and `active` is unchanged.
- Run all four channels on the same tap, each with P=1, periodic. Required: `fire`=4'b1111 for one cycle per strobe.
- Start ch3 with P=5 and assert `rst` after 2 strobes. Required: all outputs 0 next cycle; no fire on later strobes.

Source files
------------

// File: rtl/tap_timer.sv
// Bank of tap-driven countdown timers: each channel counts strobes of one selected
// timebase tap and pulses fire on expiry, one-shot or periodic.
module tap_timer #(
  parameter int unsigned NTAPS = 6,
  parameter int unsigned NCH   = 4,
  parameter int unsigned CHW   = 2,
  parameter int unsigned TSW   = 3,
  parameter int unsigned CW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NTAPS-1:0] taps,
  input  logic             cfg_valid,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic             cfg_start,
  input  logic             cfg_mode,
  input  logic [TSW-1:0]   cfg_tap,
  input  logic [CW-1:0]    cfg_period,
  output logic             cfg_err,
  output logic [NCH-1:0]   fire,
  output logic [NCH-1:0]   active,
  input  logic [CHW-1:0]   rd_ch,
  output logic [CW-1:0]    rd_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Command and strobe inputs are registered once, so a command and a strobe
  // seen at the same edge are resolved together one cycle later.
  logic             cmd_v_q, cmd_v_d;
  logic [CHW-1:0]   cmd_ch_q, cmd_ch_d;
  logic             cmd_start_q, cmd_start_d;
  logic             cmd_mode_q, cmd_mode_d;
  logic [TSW-1:0]   cmd_tap_q, cmd_tap_d;
  logic [CW-1:0]    cmd_period_q, cmd_period_d;
  logic [NTAPS-1:0] taps_q, taps_d;

  logic [TSW-1:0] tap_sel_q [NCH];
  logic [TSW-1:0] tap_sel_d [NCH];
  logic [CW-1:0]  period_q  [NCH];
  logic [CW-1:0]  period_d  [NCH];
  logic [CW-1:0]  count_q   [NCH];
  logic [CW-1:0]  count_d   [NCH];
  logic [0:0]     state_q   [NCH];
  logic [0:0]     state_d   [NCH];
  logic [NCH-1:0] mode_q, mode_d;
  logic [NCH-1:0] fire_q, fire_d;
  logic           cfg_err_q, cfg_err_d;
  logic [CW-1:0]  rd_count_q, rd_count_d;

  logic ch_ok, tap_ok, per_ok, cmd_accept;

  always_comb begin
    cmd_v_d      = cfg_valid;
    cmd_ch_d     = cfg_ch;
    cmd_start_d  = cfg_start;
    cmd_mode_d   = cfg_mode;
    cmd_tap_d    = cfg_tap;
    cmd_period_d = cfg_period;
    taps_d       = taps;

    tap_sel_d = tap_sel_q;
    period_d  = period_q;
    count_d   = count_q;
    state_d   = state_q;
    mode_d    = mode_q;
    fire_d    = '0;

    ch_ok      = 32'(cmd_ch_q) < NCH;
    tap_ok     = 32'(cmd_tap_q) < NTAPS;
    per_ok     = cmd_period_q != '0;
    cmd_accept = cmd_v_q && ch_ok && (!cmd_start_q || (tap_ok && per_ok));
    cfg_err_d  = cmd_v_q && !cmd_accept;

    for (int unsigned i = 0; i < NCH; i++) begin
      // An accepted command to this channel takes priority over its strobe.
      if (cmd_accept && cmd_ch_q == CHW'(i)) begin
        if (cmd_start_q) begin
          tap_sel_d[i] = cmd_tap_q;
          period_d[i]  = cmd_period_q;
          mode_d[i]    = cmd_mode_q;
          count_d[i]   = cmd_period_q;
          state_d[i]   = ST_RUN;
        end else begin
          count_d[i]   = '0;
          state_d[i]   = ST_IDLE;
        end
      end else if (state_q[i] == ST_RUN && taps_q[tap_sel_q[i]]) begin
        if (count_q[i] == CW'(1)) begin
          fire_d[i] = 1'b1;
          if (mode_q[i]) begin
            count_d[i] = period_q[i];
          end else begin
            count_d[i] = '0;
            state_d[i] = ST_IDLE;
          end
        end else begin
          count_d[i] = count_q[i] - CW'(1);
        end
      end
    end

    rd_count_d = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (rd_ch == CHW'(i)) rd_count_d = count_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_v_q      <= 1'b0;
      cmd_ch_q     <= '0;
      cmd_start_q  <= 1'b0;
      cmd_mode_q   <= 1'b0;
      cmd_tap_q    <= '0;
      cmd_period_q <= '0;
      taps_q       <= '0;
      tap_sel_q    <= '{default: '0};
      period_q     <= '{default: '0};
      count_q      <= '{default: '0};
      state_q      <= '{default: ST_IDLE};
      mode_q       <= '0;
      fire_q       <= '0;
      cfg_err_q    <= 1'b0;
      rd_count_q   <= '0;
    end else begin
      cmd_v_q      <= cmd_v_d;
      cmd_ch_q     <= cmd_ch_d;
      cmd_start_q  <= cmd_start_d;
      cmd_mode_q   <= cmd_mode_d;
      cmd_tap_q    <= cmd_tap_d;
      cmd_period_q <= cmd_period_d;
      taps_q       <= taps_d;
      tap_sel_q    <= tap_sel_d;
      period_q     <= period_d;
      count_q      <= count_d;
      state_q      <= state_d;
      mode_q       <= mode_d;
      fire_q       <= fire_d;
      cfg_err_q    <= cfg_err_d;
      rd_count_q   <= rd_count_d;
    end
  end

  always_comb begin
    active = '0;
    for (int unsigned i = 0; i < NCH; i++) active[i] = (state_q[i] == ST_RUN);
  end

  assign fire     = fire_q;
  assign cfg_err  = cfg_err_q;
  assign rd_count = rd_count_q;

endmodule
